// File: rtl/video_stream_aligner.sv
// Aligns a valid/ready RGB stream (sof/eol marked) to raster timing, ahead of a TMDS encoder.
// Latency 2 cycles timing-in to colour/sync-out; s_ready low while the FIFO is full, raster never stalls.
module video_stream_aligner #(
    parameter int          H_ACTIVE    = 1440,
    parameter int          V_ACTIVE    = 900,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [23:0] FILL_COLOR  = 24'h000000,
    parameter logic [23:0] UNDER_COLOR = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [10:0] h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        blank_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        blank_out,
    output logic        in_sync,
    output logic        underflow,
    output logic        misalign,
    input  logic        clr_status
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);

    typedef enum logic [1:0] {SEEK, WAIT, RUN} state_t;

    logic [25:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    logic [25:0] head;
    logic        head_sof, head_eol;

    state_t      state, nxt;
    logic        act, fstart, lend;
    logic [23:0] pix;
    logic        err_u, err_m;

    logic [23:0] s1_rgb;
    logic        s1_hs, s1_vs, s1_blank, s1_eu, s1_em;

    assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty    = wr_ptr == rd_ptr;
    assign s_ready  = rst && !full;
    assign push     = s_valid && s_ready;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign head_sof = head[25];
    assign head_eol = head[24];

    // Visible cycles beyond the configured frame height are treated as blank.
    assign act    = !blank_in && (v_cnt < V_LIM);
    assign fstart = act && (h_cnt == 11'd0) && (v_cnt == 10'd0);
    assign lend   = act && (h_cnt == H_LAST);

    always_comb begin
        nxt   = state;
        pop   = 1'b0;
        pix   = FILL_COLOR;
        err_u = 1'b0;
        err_m = 1'b0;
        case (state)
            SEEK: begin
                if (!empty) begin
                    if (head_sof) nxt = WAIT;
                    else          pop = 1'b1;
                end
            end
            WAIT: begin
                if (fstart && !empty && head_sof) begin
                    pop   = 1'b1;
                    pix   = head[23:0];
                    nxt   = RUN;
                    err_m = head_eol != lend;
                end
            end
            RUN: begin
                if (act) begin
                    if (empty) begin
                        pix   = UNDER_COLOR;
                        err_u = 1'b1;
                        nxt   = SEEK;
                    end else begin
                        pop   = 1'b1;
                        pix   = head[23:0];
                        err_m = (head_eol != lend) || (head_sof != fstart);
                    end
                end
            end
            default: nxt = SEEK;
        endcase
        if (err_m) nxt = SEEK;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {s_sof, s_eol, s_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEEK;
            in_sync    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            s1_rgb     <= '0;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            s1_blank   <= 1'b1;
            s1_eu      <= 1'b0;
            s1_em      <= 1'b0;
            red_out    <= '0;
            green_out  <= '0;
            blue_out   <= '0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            blank_out  <= 1'b1;
            underflow  <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            state   <= nxt;
            in_sync <= nxt == RUN;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            s1_rgb   <= pix;
            s1_hs    <= h_sync_in;
            s1_vs    <= v_sync_in;
            s1_blank <= blank_in;
            s1_eu    <= err_u;
            s1_em    <= err_m;

            {red_out, green_out, blue_out} <= s1_blank ? 24'h0 : s1_rgb;
            h_sync_out <= s1_hs;
            v_sync_out <= s1_vs;
            blank_out  <= s1_blank;

            // Flags rise together with the offending pixel; a new error beats a clear.
            if (s1_eu)           underflow <= 1'b1;
            else if (clr_status) underflow <= 1'b0;
            if (s1_em)           misalign  <= 1'b1;
            else if (clr_status) misalign  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_video_stream_aligner.sv
// Scenario table for video_stream_aligner, with a queue-based reference model checked every cycle.
module tb_video_stream_aligner;
    localparam int H_ACT = 8, V_ACT = 4, DEPTH = 8;
    localparam int H_TOT = 12, V_TOT = 6;
    localparam logic [23:0] FILL = 24'h000000, UNDER = 24'hFF00FF;
    localparam int M_SEEK = 0, M_WAIT = 1, M_RUN = 2;
    localparam int MAX_CYC = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_data;
    logic        s_sof, s_eol, s_valid, s_ready;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_sync_in, v_sync_in, blank_in, clr_status;
    logic [7:0]  red_out, green_out, blue_out;
    logic        h_sync_out, v_sync_out, blank_out, in_sync, underflow, misalign;

    video_stream_aligner #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .FIFO_DEPTH(DEPTH),
        .FILL_COLOR(FILL), .UNDER_COLOR(UNDER)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .s_valid(s_valid), .s_ready(s_ready),
        .h_cnt(h_cnt), .v_cnt(v_cnt),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .blank_in(blank_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .blank_out(blank_out),
        .in_sync(in_sync), .underflow(underflow), .misalign(misalign),
        .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        int          gap;
    } beat_t;

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        uset;
        logic        mset;
    } exp_t;

    typedef struct {
        int junk;
        int stall_frame, stall_line, stall_pix;
        int bad_frame, bad_line, bad_pix;
        int hold_frame, hold_len;
        int clr_frame;
        int rst_frame;
        bit rand_idle;
        bit xs_u, xs_m, xe_u, xe_m, xe_sync;
    } row_t;

    beat_t       src_q[$];
    logic [25:0] mq[$];
    exp_t        pipe[$];
    int          mode;
    logic        u_m, m_m;
    bit          src_holding;
    int          h, v, rframe, hold_cnt;
    bit          held, pol, seen_u, seen_m;
    int          checks = 0, errors = 0;
    row_t        rows[6];

    task automatic chk(input string what, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (frame %0d v %0d h %0d)", what, got, want, rframe, v, h);
        end
    endtask

    task automatic do_reset(input bit check_now);
        rst = 1'b0;
        #1;
        if (check_now) begin
            chk("rst_rgb", {red_out, green_out, blue_out}, 24'h0);
            chk("rst_hsync", h_sync_out, 1'b0);
            chk("rst_vsync", v_sync_out, 1'b0);
            chk("rst_blank", blank_out, 1'b1);
            chk("rst_in_sync", in_sync, 1'b0);
            chk("rst_underflow", underflow, 1'b0);
            chk("rst_misalign", misalign, 1'b0);
            chk("rst_s_ready", s_ready, 1'b0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        mq.delete();
        pipe.delete();
        pipe.push_back('{rgb: 24'h0, hs: 1'b0, vs: 1'b0, blank: 1'b1, uset: 1'b0, mset: 1'b0});
        mode = M_SEEK;
        u_m = 1'b0;
        m_m = 1'b0;
        src_holding = 1'b0;
        rst = 1'b1;
    endtask

    task automatic drive_cycle(input bit clr, input bit rand_idle);
        bit present;
        h_cnt      = 11'(h);
        v_cnt      = 10'(v);
        blank_in   = (h >= H_ACT) || (v >= V_ACT);
        h_sync_in  = ((h >= 9) && (h < 11)) ^ pol;
        v_sync_in  = (v == 4) ^ pol;
        clr_status = clr;
        s_valid    = 1'b0;
        s_data     = 24'($urandom);
        s_sof      = 1'($urandom);
        s_eol      = 1'($urandom);
        present    = 1'b0;
        if (src_q.size() > 0) begin
            if (src_holding) present = 1'b1;
            else if (src_q[0].gap > 0) src_q[0].gap = src_q[0].gap - 1;
            else if (rand_idle && mq.size() >= 4 && $urandom_range(0, 3) == 0) present = 1'b0;
            else present = 1'b1;
        end
        if (present) begin
            s_valid = 1'b1;
            s_data  = src_q[0].data;
            s_sof   = src_q[0].sof;
            s_eol   = src_q[0].eol;
        end
    endtask

    // Reference: a queue holds the buffered beats; each cycle applies the seek/wait/run rules.
    task automatic model_cycle();
        logic        act, fstart, lend, ready;
        logic [25:0] hd;
        exp_t        e;
        act    = !blank_in;
        fstart = act && (h == 0) && (v == 0);
        lend   = act && (h == H_ACT - 1);
        ready  = mq.size() < DEPTH;
        hd     = (mq.size() > 0) ? mq[0] : 26'h0;
        e = '{rgb: FILL, hs: h_sync_in, vs: v_sync_in, blank: blank_in, uset: 1'b0, mset: 1'b0};
        if (mode == M_SEEK) begin
            if (mq.size() > 0) begin
                if (hd[25]) mode = M_WAIT;
                else mq.delete(0);
            end
        end else if (mode == M_WAIT) begin
            if (fstart && mq.size() > 0 && hd[25]) begin
                mq.delete(0);
                e.rgb = hd[23:0];
                mode  = M_RUN;
                if (hd[24] != lend) begin e.mset = 1'b1; mode = M_SEEK; end
            end
        end else if (act) begin
            if (mq.size() == 0) begin
                e.rgb  = UNDER;
                e.uset = 1'b1;
                mode   = M_SEEK;
            end else begin
                mq.delete(0);
                e.rgb = hd[23:0];
                if ((hd[24] != lend) || (hd[25] != fstart)) begin e.mset = 1'b1; mode = M_SEEK; end
            end
        end
        if (blank_in) e.rgb = 24'h0;
        pipe.push_back(e);
        if (s_valid && ready) begin
            mq.push_back({s_sof, s_eol, s_data});
            src_q.delete(0);
            src_holding = 1'b0;
        end else begin
            src_holding = s_valid;
        end
    endtask

    task automatic compare_cycle(input bit clr);
        exp_t e;
        e = pipe.pop_front();
        if (e.uset) u_m = 1'b1; else if (clr) u_m = 1'b0;
        if (e.mset) m_m = 1'b1; else if (clr) m_m = 1'b0;
        chk("rgb", {red_out, green_out, blue_out}, e.rgb);
        chk("h_sync_out", h_sync_out, e.hs);
        chk("v_sync_out", v_sync_out, e.vs);
        chk("blank_out", blank_out, e.blank);
        chk("in_sync", in_sync, mode == M_RUN);
        chk("underflow", underflow, u_m);
        chk("misalign", misalign, m_m);
        chk("s_ready", s_ready, mq.size() < DEPTH);
        seen_u = seen_u | underflow;
        seen_m = seen_m | misalign;
    endtask

    task automatic raster_advance(input row_t r);
        if (hold_cnt > 0) begin
            hold_cnt--;
        end else begin
            h++;
            if (h == H_TOT) begin
                h = 0;
                v++;
                if (v == V_TOT) begin v = 0; rframe++; end
            end
        end
        if (!held && rframe == r.hold_frame && v == 1 && h == H_ACT) begin
            hold_cnt = r.hold_len;
            held     = 1'b1;
        end
    endtask

    task automatic build_src(input row_t r);
        beat_t b;
        int    pend;
        src_q.delete();
        pend = 0;
        for (int j = 0; j < r.junk; j++)
            src_q.push_back('{data: 24'($urandom), sof: 1'b0, eol: 1'($urandom), gap: 0});
        for (int f = 0; f < 6; f++)
            for (int l = 0; l < V_ACT; l++)
                for (int p = 0; p < H_ACT; p++) begin
                    if (f == r.stall_frame && (l > r.stall_line || (l == r.stall_line && p >= r.stall_pix))) begin
                        pend = 60;
                    end else begin
                        b.data = {8'(8'hA0 + l), 8'($urandom), 8'(p)};
                        b.sof  = (l == 0) && (p == 0);
                        b.eol  = (p == H_ACT - 1);
                        if (f == r.bad_frame && l == r.bad_line) b.eol = (p == r.bad_pix);
                        b.gap  = pend;
                        pend   = 0;
                        src_q.push_back(b);
                    end
                end
    endtask

    task automatic run_row(input row_t r, input int idx);
        int cyc;
        bit clr, done_rst;
        build_src(r);
        pol = 1'($urandom);
        do_reset(1'b1);
        h = 0; v = V_ACT; rframe = -1;
        hold_cnt = 0; held = 1'b0; seen_u = 1'b0; seen_m = 1'b0;
        cyc = 0; done_rst = 1'b0;
        while (rframe < 4 && cyc < MAX_CYC) begin
            if (r.rst_frame == rframe && v == 2 && h == 3 && !done_rst) begin
                done_rst = 1'b1;
                do_reset(1'b1);
            end
            clr = (r.clr_frame == rframe) && (v == 1) && (h == 0);
            drive_cycle(clr, r.rand_idle);
            model_cycle();
            @(posedge clk);
            #1;
            compare_cycle(clr);
            raster_advance(r);
            cyc++;
        end
        chk($sformatf("row%0d_in_time", idx), cyc < MAX_CYC, 1'b1);
        chk($sformatf("row%0d_seen_underflow", idx), seen_u, r.xs_u);
        chk($sformatf("row%0d_seen_misalign", idx), seen_m, r.xs_m);
        chk($sformatf("row%0d_end_underflow", idx), underflow, r.xe_u);
        chk($sformatf("row%0d_end_misalign", idx), misalign, r.xe_m);
        chk($sformatf("row%0d_end_in_sync", idx), in_sync, r.xe_sync);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
        h_cnt = '0; v_cnt = '0; h_sync_in = 1'b0; v_sync_in = 1'b0; blank_in = 1'b1; clr_status = 1'b0;
        mode = M_SEEK; u_m = 1'b0; m_m = 1'b0; src_holding = 1'b0;
        h = 0; v = 0; rframe = -1; hold_cnt = 0; held = 1'b0; pol = 1'b0;
        //          junk stall(f,l,p) bad_eol(f,l,p) hold(f,len) clr rst  rnd  seen u/m  end u/m  sync
        rows[0] = '{0,  -1, 0, 0,     -1, 0, 0,      -1, 0,      -1, -1,  1,   0, 0,     0, 0,    1};
        rows[1] = '{5,  -1, 0, 0,     -1, 0, 0,      -1, 0,      -1, -1,  0,   0, 0,     0, 0,    1};
        rows[2] = '{0,   0, 1, 3,     -1, 0, 0,      -1, 0,      -1, -1,  0,   1, 0,     1, 0,    1};
        rows[3] = '{0,  -1, 0, 0,      1, 2, 6,      -1, 0,       3, -1,  1,   0, 1,     0, 0,    1};
        rows[4] = '{0,  -1, 0, 0,     -1, 0, 0,       1, 60,     -1, -1,  1,   0, 0,     0, 0,    1};
        rows[5] = '{0,  -1, 0, 0,     -1, 0, 0,      -1, 0,      -1,  1,  1,   0, 0,     0, 0,    1};
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) run_row(rows[i], i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
